// File: rtl/oc8051_acc_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oc8051_acc_wr_arb_pkg
//  Description : Shared oc8051 encodings used by the ACC write-port arbiter:
//                writeback selects, ACC SFR address, bit-addressable ACC
//                prefix, default starvation limit, arbiter FSM encoding and
//                an ACC-write decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package oc8051_acc_wr_arb_pkg;

    // ALU writeback selects
    localparam logic [1:0] OC8051_WRS_N    = 2'b00;
    localparam logic [1:0] OC8051_WRS_ACC1 = 2'b01;
    localparam logic [1:0] OC8051_WRS_ACC2 = 2'b10;

    // ACC byte address and the 5-bit prefix of its bit addresses (E0..E7)
    localparam logic [7:0] OC8051_SFR_ACC   = 8'he0;
    localparam logic [4:0] OC8051_SFR_B_ACC = 5'b11100;

    // Default number of wait cycles before a forced core stall
    localparam int OC8051_ACC_STARVE_DEF = 15;

    // Starvation FSM encoding
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // True when the core touches ACC in this cycle, by ALU writeback, by a
    // direct byte write to the ACC address, or by a bit write into ACC.
    function automatic logic is_acc_write(
        input logic       wr,
        input logic       wr_bit,
        input logic [7:0] wr_addr,
        input logic [1:0] wr_sfr
    );
        return (wr_sfr == OC8051_WRS_ACC1) ||
               (wr_sfr == OC8051_WRS_ACC2) ||
               (wr && !wr_bit && (wr_addr == OC8051_SFR_ACC)) ||
               (wr &&  wr_bit && (wr_addr[7:3] == OC8051_SFR_B_ACC));
    endfunction

endpackage
`default_nettype wire

// File: rtl/oc8051_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : oc8051_rr_arb2
//  Description : Two-way round-robin grant with a one-bit preference pointer.
//                The grant is combinational; the pointer moves to the other
//                port after every grant, so a port is never served twice in a
//                row while the other one is waiting.
//  Ports       : clk, rst (async, active-high)
//                en   - a free slot exists this cycle
//                req  - per-port request
//                gnt  - one-hot grant (zero when en=0 or no request)
//  Revision    : 1.0  initial release
// ============================================================================
module oc8051_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_rr;     // preferred port when both request

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_rr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer names the port that was not just granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (|gnt) begin
            r_rr <= ~gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/oc8051_acc_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : oc8051_acc_wr_arb
//  Description : Shares the accumulator write port between the core pipeline
//                (always wins) and two auxiliary requesters (port 0 debug,
//                port 1 coprocessor) served round-robin in free cycles. A
//                starvation counter requests a one-cycle core stall so a
//                waiting aux write can complete.
//  Ports       : clk, rst (async, active-high)
//                core_*      - core write interface (passed through)
//                aux_req/bit/idx*/data*  - aux request and payload
//                aux_ack     - per-port pulse in the cycle its write is driven
//                core_stall  - registered forced-slot request
//                err         - sticky: core wrote ACC during a stall cycle
//                wr..data2_in - ACC write interface
//  Revision    : 1.0  initial release
// ============================================================================
module oc8051_acc_wr_arb
    import oc8051_acc_wr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = OC8051_ACC_STARVE_DEF,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_wr,
    input  logic       core_wr_bit,
    input  logic [7:0] core_wr_addr,
    input  logic [7:0] core_data,
    input  logic       core_bit,
    input  logic [1:0] core_wr_sfr,
    input  logic [7:0] core_data2,
    input  logic [1:0] aux_req,
    input  logic [1:0] aux_bit,
    input  logic [2:0] aux_idx0,
    input  logic [2:0] aux_idx1,
    input  logic [7:0] aux_data0,
    input  logic [7:0] aux_data1,
    output logic [1:0] aux_ack,
    output logic       core_stall,
    output logic       err,
    output logic       wr,
    output logic       wr_bit,
    output logic [7:0] wr_addr,
    output logic [7:0] data_in,
    output logic       bit_in,
    output logic [1:0] wr_sfr,
    output logic [7:0] data2_in
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

    logic             w_core_acc;   // core writes ACC this cycle
    logic             w_bus_free;   // core does not drive the write bus
    logic [1:0]       w_gnt;
    logic             w_sel;        // granted port index
    logic [2:0]       w_idx;
    logic [7:0]       w_dat;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_err;

    assign w_core_acc = is_acc_write(core_wr, core_wr_bit, core_wr_addr, core_wr_sfr);

    // Any core bus activity (ACC or other SFR) keeps the aux writes off the bus.
    assign w_bus_free = !core_wr && (core_wr_sfr == OC8051_WRS_N);

    // Reset gates the slot so no ack or aux drive appears while rst is high.
    oc8051_rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (w_bus_free && !rst),
        .req (aux_req),
        .gnt (w_gnt)
    );

    assign aux_ack = w_gnt;
    assign w_sel   = w_gnt[1];
    assign w_idx   = w_sel ? aux_idx1  : aux_idx0;
    assign w_dat   = w_sel ? aux_data1 : aux_data0;

    // ACC write bus: core passes through unless an aux port holds the slot
    always_comb begin
        wr       = core_wr;
        wr_bit   = core_wr_bit;
        wr_addr  = core_wr_addr;
        data_in  = core_data;
        bit_in   = core_bit;
        wr_sfr   = core_wr_sfr;
        data2_in = core_data2;
        if (|w_gnt) begin
            wr      = 1'b1;
            wr_bit  = aux_bit[w_sel];
            wr_addr = aux_bit[w_sel] ? {OC8051_SFR_B_ACC, w_idx} : OC8051_SFR_ACC;
            data_in = w_dat;
            bit_in  = aux_bit[w_sel] & w_dat[0];
            wr_sfr  = OC8051_WRS_N;
        end
    end

    // Starvation counter: counts unserved request cycles, saturating
    always_comb begin
        w_cnt_nxt = '0;
        if ((|aux_req) && !(|w_gnt)) begin
            w_cnt_nxt = (r_cnt == c_limit) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Starvation FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter STALL as the counter reaches the limit so the stall
    // lands in the very next cycle; STALL always lasts one cycle. A core
    // write during STALL leaves the counter saturated, which re-enters STALL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   w_state_nxt = (w_cnt_nxt == c_limit) ? ST_STALL : ST_RUN;
            ST_STALL: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Outputs: core_stall decodes directly from the state register
    always_comb begin
        core_stall = (r_state == ST_STALL);
    end

    // Sticky contract-violation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_STALL) && w_core_acc) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_oc8051_acc_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oc8051_acc_wr_arb
//  Description : Self-checking bench for oc8051_acc_wr_arb: directed steps
//                from the test plan followed by randomized traffic, checked
//                against a cycle-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oc8051_acc_wr_arb;

    localparam int LIMIT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_wr, core_wr_bit, core_bit;
    logic [7:0] core_wr_addr, core_data, core_data2;
    logic [1:0] core_wr_sfr;
    logic [1:0] aux_req, aux_bit;
    logic [2:0] aux_idx0, aux_idx1;
    logic [7:0] aux_data0, aux_data1;
    logic [1:0] aux_ack;
    logic       core_stall, err;
    logic       wr, wr_bit, bit_in;
    logic [7:0] wr_addr, data_in, data2_in;
    logic [1:0] wr_sfr;

    oc8051_acc_wr_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .core_wr(core_wr), .core_wr_bit(core_wr_bit), .core_wr_addr(core_wr_addr),
        .core_data(core_data), .core_bit(core_bit), .core_wr_sfr(core_wr_sfr),
        .core_data2(core_data2),
        .aux_req(aux_req), .aux_bit(aux_bit), .aux_idx0(aux_idx0), .aux_idx1(aux_idx1),
        .aux_data0(aux_data0), .aux_data1(aux_data1),
        .aux_ack(aux_ack), .core_stall(core_stall), .err(err),
        .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .data_in(data_in),
        .bit_in(bit_in), .wr_sfr(wr_sfr), .data2_in(data2_in)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_rr, m_cnt;
    bit m_stall, m_err;

    // Values observed in the last step, for directed checks
    logic [1:0] obs_ack;
    logic       obs_stall, obs_err, obs_wr, obs_wrbit;
    logic [7:0] obs_addr, obs_din;
    logic [7:0] tb_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_cnt = 0; m_stall = 0; m_err = 0;
    endtask

    task automatic set_rst();
        rst = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic core_idle();
        core_wr = 0; core_wr_bit = 0; core_wr_addr = 8'h00; core_bit = 0;
        core_wr_sfr = 2'b00; core_data = 8'h00; core_data2 = 8'h00;
    endtask

    // One clock cycle: predict, sample at negedge, advance the model at posedge
    task automatic step();
        logic [1:0] e_ack;
        int         p;
        logic       cacc, free;
        logic       e_wr, e_wrbit, e_bitin;
        logic [7:0] e_addr, e_din, d;
        logic [2:0] ix;
        logic [1:0] e_sfr;
        cacc = (core_wr_sfr == 2'd1) || (core_wr_sfr == 2'd2) ||
               (core_wr && !core_wr_bit && core_wr_addr == 8'hE0) ||
               (core_wr && core_wr_bit && core_wr_addr[7:3] == 5'h1C);
        free = !core_wr && (core_wr_sfr == 2'd0);
        e_ack = 2'b00; p = 0;
        if (!rst && free && aux_req != 2'b00) begin
            if (aux_req == 2'b11) p = m_rr;
            else p = aux_req[1] ? 1 : 0;
            e_ack = (p == 1) ? 2'b10 : 2'b01;
        end
        e_wr = core_wr; e_wrbit = core_wr_bit; e_addr = core_wr_addr;
        e_din = core_data; e_bitin = core_bit; e_sfr = core_wr_sfr;
        if (e_ack != 2'b00) begin
            d  = (p == 1) ? aux_data1 : aux_data0;
            ix = (p == 1) ? aux_idx1  : aux_idx0;
            e_wr = 1'b1; e_wrbit = aux_bit[p]; e_sfr = 2'b00; e_din = d;
            e_addr  = aux_bit[p] ? {5'h1C, ix} : 8'hE0;
            e_bitin = aux_bit[p] ? d[0] : 1'b0;
        end
        @(negedge clk);
        chk("aux_ack", aux_ack, e_ack);
        chk("wr", wr, e_wr);
        chk("wr_bit", wr_bit, e_wrbit);
        chk("wr_addr", wr_addr, e_addr);
        chk("data_in", data_in, e_din);
        chk("bit_in", bit_in, e_bitin);
        chk("wr_sfr", wr_sfr, e_sfr);
        chk("data2_in", data2_in, core_data2);
        chk("core_stall", core_stall, m_stall);
        chk("err", err, m_err);
        obs_ack = aux_ack; obs_stall = core_stall; obs_err = err;
        obs_wr = wr; obs_wrbit = wr_bit; obs_addr = wr_addr; obs_din = data_in;
        if (wr && !wr_bit && wr_addr == 8'hE0) tb_acc = data_in;
        else if (wr && wr_bit && wr_addr[7:3] == 5'h1C) tb_acc[wr_addr[2:0]] = bit_in;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_ack != 2'b00) m_rr = 1 - p;
            if (m_stall && cacc) m_err = 1;
            if (aux_req != 2'b00 && e_ack == 2'b00) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
            else m_cnt = 0;
            m_stall = m_stall ? 1'b0 : (m_cnt == LIMIT);
        end
        #1;
    endtask

    task automatic reset_cycle();
        aux_req = 2'b00;
        core_idle();
        set_rst();
        step();
        rst = 1'b0;
    endtask

    // Random core activity: ACC writes (any form) or non-ACC SFR writes
    task automatic rand_core(input bit acc);
        int k;
        core_idle();
        core_data  = 8'($urandom);
        core_data2 = 8'($urandom);
        core_bit   = 1'($urandom);
        if (acc) begin
            k = $urandom_range(0, 3);
            case (k)
                0: core_wr_sfr = 2'b01;
                1: core_wr_sfr = 2'b10;
                2: begin core_wr = 1; core_wr_addr = 8'hE0; end
                default: begin core_wr = 1; core_wr_bit = 1; core_wr_addr = {5'h1C, 3'($urandom)}; end
            endcase
        end else begin
            core_wr = 1; core_wr_bit = 1'($urandom);
            core_wr_addr = 8'($urandom);
            if (core_wr_addr == 8'hE0 || core_wr_addr[7:3] == 5'h1C) core_wr_addr = 8'h81;
        end
    endtask

    task automatic new_payload(input int p);
        if (p == 0) begin
            aux_bit[0] = 1'($urandom); aux_idx0 = 3'($urandom); aux_data0 = 8'($urandom);
        end else begin
            aux_bit[1] = 1'($urandom); aux_idx1 = 3'($urandom); aux_data1 = 8'($urandom);
        end
    endtask

    initial begin
        int burst;
        int r;
        logic [1:0] alt_exp [4];
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
        aux_bit = 2'b00; aux_idx0 = 3'd0; aux_idx1 = 3'd0; aux_data0 = 8'h00; aux_data1 = 8'h00;
        tb_acc = 8'h00;

        // Reset state
        reset_cycle();
        chk("rst_ack", obs_ack, 2'b00);
        chk("rst_stall", obs_stall, 1'b0);
        chk("rst_err", obs_err, 1'b0);
        chk("rst_wr", obs_wr, 1'b0);

        // Port 0 byte write in a free slot
        tb_acc = 8'h00;
        aux_req = 2'b01; aux_bit = 2'b00; aux_data0 = 8'h5A;
        step();
        chk("byte_ack", obs_ack, 2'b01);
        chk("byte_wr", obs_wr, 1'b1);
        chk("byte_addr", obs_addr, 8'hE0);
        chk("byte_data", obs_din, 8'h5A);
        aux_req = 2'b00;
        chk("byte_acc", tb_acc, 8'h5A);
        step();

        // Both ports held: acks alternate starting at port 0 after reset
        reset_cycle();
        aux_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            new_payload(0); new_payload(1);
            step();
            chk("rr_alt", obs_ack, alt_exp[i]);
        end
        aux_req = 2'b00;
        step();

        // Port 1 bit write, index 5, bit value 1
        tb_acc = 8'h00;
        aux_req = 2'b10; aux_bit = 2'b10; aux_idx1 = 3'd5; aux_data1 = 8'h01;
        step();
        chk("bit_ack", obs_ack, 2'b10);
        chk("bit_wrbit", obs_wrbit, 1'b1);
        chk("bit_addr", obs_addr, 8'hE5);
        chk("bit_acc", tb_acc, 8'h20);
        aux_req = 2'b00; aux_bit = 2'b00;
        step();

        // Starvation: core writes ACC for 15 cycles, stall cycle grants port 0
        reset_cycle();
        core_wr_sfr = 2'b01; aux_req = 2'b01; aux_data0 = 8'hC3;
        for (int i = 0; i < LIMIT; i++) begin
            step();
            chk("starve_noack", obs_ack, 2'b00);
        end
        core_idle();
        step();
        chk("starve_stall", obs_stall, 1'b1);
        chk("starve_ack", obs_ack, 2'b01);
        aux_req = 2'b00;
        step();
        chk("starve_release", obs_stall, 1'b0);

        // Core writes during the stall: err, no ack, stall comes back
        reset_cycle();
        core_wr_sfr = 2'b10; aux_req = 2'b01;
        for (int i = 0; i < LIMIT; i++) step();
        step();
        chk("viol_stall", obs_stall, 1'b1);
        chk("viol_noack", obs_ack, 2'b00);
        step();
        chk("viol_err", obs_err, 1'b1);
        chk("viol_run", obs_stall, 1'b0);
        core_idle();
        step();
        chk("viol_restall", obs_stall, 1'b1);
        chk("viol_ack", obs_ack, 2'b01);
        aux_req = 2'b00;
        step();
        step();
        chk("viol_sticky", obs_err, 1'b1);

        // Asynchronous reset in the middle of a stall with port 1 waiting
        reset_cycle();
        core_wr_sfr = 2'b01; aux_req = 2'b10; aux_bit = 2'b00; aux_data1 = 8'h77;
        for (int i = 0; i < LIMIT; i++) step();
        chk("mid_stall", core_stall, 1'b1);
        core_idle();
        #1;
        set_rst();
        chk("async_stall", core_stall, 1'b0);
        chk("async_ack", aux_ack, 2'b00);
        chk("async_err", err, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ack", obs_ack, 2'b10);
        aux_req = 2'b00;
        step();

        // Randomized traffic
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (burst > 0) begin
                burst--;
                rand_core(1);
            end else begin
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    burst = $urandom_range(5, 2 * LIMIT);
                    rand_core(1);
                end else if (m_stall) begin
                    if (r == 1) rand_core(1);
                    else core_idle();
                end else if (r < 6) begin
                    rand_core(1);
                end else if (r < 10) begin
                    rand_core(0);
                end else begin
                    core_idle();
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                set_rst();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
            for (int p = 0; p < 2; p++) begin
                if (obs_ack[p]) begin
                    new_payload(p);
                    aux_req[p] = 1'($urandom);
                end else if (!aux_req[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        new_payload(p);
                        aux_req[p] = 1'b1;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    aux_req[p] = 1'b0;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
